// File: rtl/clken_pkg.sv
// Shared types and helpers for the clken_synth enable synthesiser.
// Holds the config request record, channel-index width and legality rule.
package clken_pkg;

    localparam int ACC_W_DEF = 16;

    // Request record is sized for the widest legal build:
    // up to 8 channels and up to 32-bit ratios.
    localparam int REQ_CH_W  = 3;
    localparam int REQ_VAL_W = 32;

    typedef struct packed {
        logic [REQ_CH_W-1:0]  chan;
        logic [REQ_VAL_W-1:0] num;
        logic [REQ_VAL_W-1:0] den;
    } cfg_req_t;

    // Channel select width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A ratio above one, a zero divisor or a missing
    // channel would make the accumulator meaningless.
    function automatic logic cfg_legal(
        input cfg_req_t r,
        input int       n
    );
        logic [31:0] nch;
        nch = n[31:0];
        return (r.den != '0) &&
               (r.num <= r.den) &&
               ({29'b0, r.chan} < nch);
    endfunction

endpackage

// File: rtl/clken_channel.sv
// One fractional clock-enable channel: ce averages f_clk*num/den.
// Ports: clock_in/reset_n; run (locked), apply + apply_num/apply_den load a
// new ratio; hit = this edge pulses; num_zero = channel off; ce = pulse out;
// toggle (only with CLKEN_TOGGLE_EN) flips on every pulse.
module clken_channel
    import clken_pkg::*;
#(
    parameter int ACC_W       = ACC_W_DEF,
    parameter int DEFAULT_NUM = 1,
    parameter int DEFAULT_DEN = 5
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic             apply,
    input  logic [ACC_W-1:0] apply_num,
    input  logic [ACC_W-1:0] apply_den,
    output logic             hit,
    output logic             num_zero,
`ifdef CLKEN_TOGGLE_EN
    output logic             toggle,
`endif
    output logic             ce
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] num_q;
    logic [ACC_W-1:0] den_q;
    logic [ACC_W:0]   sum;

    // One extra bit so acc+num never wraps.
    assign sum      = {1'b0, acc_q} + {1'b0, num_q};
    assign hit      = run && (sum >= {1'b0, den_q});
    assign num_zero = (num_q == '0);

    // acc stays below den, so sum-den and a
    // non-hitting sum both fit back in ACC_W.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            num_q <= ACC_W'(DEFAULT_NUM);
            den_q <= ACC_W'(DEFAULT_DEN);
            ce    <= 1'b0;
        end else begin
            ce <= hit;
            if (apply) begin
                num_q <= apply_num;
                den_q <= apply_den;
                acc_q <= '0;
            end else if (hit) begin
                acc_q <= ACC_W'(sum - {1'b0, den_q});
            end else if (run) begin
                acc_q <= sum[ACC_W-1:0];
            end else begin
                acc_q <= '0;
            end
        end
    end

`ifdef CLKEN_TOGGLE_EN
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            toggle <= 1'b0;
        end else if (hit) begin
            toggle <= ~toggle;
        end
    end
`endif

endmodule

// File: rtl/clken_synth.sv
// Multi-channel fractional clock-enable synthesiser with startup lock.
// Ports: clock_in, reset_n (async low); cfg_valid/cfg_ready/cfg_chan/
// cfg_num/cfg_den config handshake, cfg_err reject pulse; ce_out per-channel
// enables; locked after LOCK_CYCLES edges. Define CLKEN_TOGGLE_EN to add
// clk_toggle, a per-channel square wave at half the enable rate.
// ACC_W must not exceed 32 and CHANNELS must be 1..8.
module clken_synth
    import clken_pkg::*;
#(
    parameter int  CHANNELS    = 2,
    parameter int  ACC_W       = ACC_W_DEF,
    parameter int  LOCK_CYCLES = 1024,
    parameter int  DEFAULT_NUM = 1,
    parameter int  DEFAULT_DEN = 5,
    localparam int CH_W        = ch_w(CHANNELS)
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] ce_out,
`ifdef CLKEN_TOGGLE_EN
    output logic [CHANNELS-1:0] clk_toggle,
`endif
    output logic                locked
);

    localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_CYCLES - 1);

    logic [LCNT_W-1:0]   lock_cnt_q;
    logic                pending_q;
    logic [CH_W-1:0]     pend_chan_q;
    logic [ACC_W-1:0]    pend_num_q;
    logic [ACC_W-1:0]    pend_den_q;

    cfg_req_t            req;
    logic                legal;
    logic                accept;
    logic [CHANNELS-1:0] apply;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] num_zero;

    always_comb begin
        req      = '0;
        req.chan = REQ_CH_W'(cfg_chan);
        req.num  = REQ_VAL_W'(cfg_num);
        req.den  = REQ_VAL_W'(cfg_den);
    end

    assign legal     = cfg_legal(req, CHANNELS);
    assign accept    = cfg_valid && !pending_q;
    assign cfg_ready = !pending_q;

    // Lock counter stops once locked; locked is sticky until reset.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt_q <= '0;
            locked     <= 1'b0;
        end else if (!locked) begin
            if (lock_cnt_q == LOCK_LAST) begin
                locked <= 1'b1;
            end else begin
                lock_cnt_q <= lock_cnt_q + 1'b1;
            end
        end
    end

    // Single pending slot; a rejected request leaves it untouched.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            pend_chan_q <= '0;
            pend_num_q  <= '0;
            pend_den_q  <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= accept && !legal;
            if (|apply) begin
                pending_q <= 1'b0;
            end else if (accept && legal) begin
                pending_q   <= 1'b1;
                pend_chan_q <= cfg_chan;
                pend_num_q  <= cfg_num;
                pend_den_q  <= cfg_den;
            end
        end
    end

    // Swap ratios on a pulse edge so no period is cut short;
    // an idle or not-yet-running channel has no phase to keep.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign apply[g] = pending_q &&
                          (pend_chan_q == CH_W'(g)) &&
                          (!locked || num_zero[g] || hit[g]);

        clken_channel #(
            .ACC_W       (ACC_W),
            .DEFAULT_NUM (DEFAULT_NUM),
            .DEFAULT_DEN (DEFAULT_DEN)
        ) u_ch (
            .clock_in  (clock_in),
            .reset_n   (reset_n),
            .run       (locked),
            .apply     (apply[g]),
            .apply_num (pend_num_q),
            .apply_den (pend_den_q),
            .hit       (hit[g]),
            .num_zero  (num_zero[g]),
`ifdef CLKEN_TOGGLE_EN
            .toggle    (clk_toggle[g]),
`endif
            .ce        (ce_out[g])
        );
    end

endmodule

// File: tb/tb_clken_synth.sv
// Self-checking bench for clken_synth: ratio-formula model plus
// directed scenarios with hand-computed pulse counts and edge numbers.
module tb_clken_synth;

    localparam int NCH  = 3;
    localparam int LOCK = 16;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [1:0]     cfg_chan  = '0;
    logic [15:0]    cfg_num   = '0;
    logic [15:0]    cfg_den   = '0;
    logic           cfg_ready;
    logic           cfg_err;
    logic [NCH-1:0] ce_out;
    logic           locked;
`ifdef CLKEN_TOGGLE_EN
    logic [NCH-1:0] clk_toggle;
`endif

    clken_synth #(
        .CHANNELS    (NCH),
        .ACC_W       (16),
        .LOCK_CYCLES (LOCK),
        .DEFAULT_NUM (1),
        .DEFAULT_DEN (5)
    ) dut (
        .clock_in  (clk),
        .reset_n   (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_err   (cfg_err),
        .ce_out    (ce_out),
`ifdef CLKEN_TOGGLE_EN
        .clk_toggle(clk_toggle),
`endif
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: after k running steps from a cleared accumulator the
    // pulse count is floor(k*num/den); a pulse fires when it grows.
    int             m_num [NCH];
    int             m_den [NCH];
    longint         m_k   [NCH];
    logic [NCH-1:0] m_ce;
    logic [NCH-1:0] m_tog;
    logic           m_locked;
    logic           m_err;
    logic           m_pend;
    int             m_pchan, m_pnum, m_pden;
    int             m_edges;

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_num[i] = 1;
            m_den[i] = 5;
            m_k[i]   = 0;
        end
        m_ce = '0; m_tog = '0; m_locked = 0; m_err = 0;
        m_pend = 0; m_pchan = 0; m_pnum = 0; m_pden = 0;
        m_edges = 0;
    endtask

    task automatic m_step();
        logic [NCH-1:0] fire, app;
        logic lg, acc;
        m_edges++;
        for (int i = 0; i < NCH; i++) begin
            fire[i] = m_locked && (m_num[i] != 0) &&
                      (((m_k[i] + 1) * m_num[i]) / m_den[i] !=
                       (m_k[i] * m_num[i]) / m_den[i]);
            app[i] = m_pend && (m_pchan == i) &&
                     (!m_locked || m_num[i] == 0 || fire[i]);
        end
        for (int i = 0; i < NCH; i++) begin
            if (app[i]) begin
                m_num[i] = m_pnum; m_den[i] = m_pden; m_k[i] = 0;
            end else if (m_locked) begin
                m_k[i]++;
            end
        end
        m_ce  = fire;
        m_tog = m_tog ^ fire;
        lg  = (cfg_den != 0) && (cfg_num <= cfg_den) && (cfg_chan < NCH);
        acc = cfg_valid && !m_pend;
        m_err = acc && !lg;
        if (|app) m_pend = 0;
        else if (acc && lg) begin
            m_pend = 1; m_pchan = int'(cfg_chan);
            m_pnum = int'(cfg_num); m_pden = int'(cfg_den);
        end
        if (m_edges >= LOCK) m_locked = 1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ce_out", 64'(ce_out), 64'(m_ce));
                chk("locked", 64'(locked), 64'(m_locked));
                chk("cfg_ready", 64'(cfg_ready), 64'(!m_pend));
                chk("cfg_err", 64'(cfg_err), 64'(m_err));
`ifdef CLKEN_TOGGLE_EN
                chk("clk_toggle", 64'(clk_toggle), 64'(m_tog));
`endif
            end
        end
    end

    task automatic drive(input logic v, input int ch, input int n,
                         input int d);
        cfg_valid = v;
        cfg_chan  = 2'(ch);
        cfg_num   = 16'(n);
        cfg_den   = 16'(d);
    endtask

    // Caller is at a negedge; waits until cfg_ready, bounded.
    task automatic wait_ready(input string nm, output logic ce_at);
        int t;
        t = 0;
        ce_at = 1'b0;
        while (t < 40) begin
            @(negedge clk);
            if (cfg_ready) break;
            t++;
        end
        chk({nm, "_ready_in_time"}, 64'(t < 40), 64'd1);
        ce_at = ce_out[0];
        if (nm == "ch1") ce_at = ce_out[1];
    endtask

    // Releases reset at a negedge and pins lock and first-pulse edges.
    task automatic startup_check(input string nm);
        int   first_lock, p1, p2;
        logic early;
        logic [NCH-1:0] ce21;
        first_lock = -1; p1 = -1; p2 = -1; early = 0; ce21 = '0;
        rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (locked && first_lock < 0) first_lock = c;
            if (!locked && ce_out != '0) early = 1;
            if (ce_out[0]) begin
                if (p1 < 0) p1 = c;
                else if (p2 < 0) p2 = c;
            end
            if (c == 21) ce21 = ce_out;
        end
        chk({nm, "_lock_edge"}, 64'(first_lock), 64'd16);
        chk({nm, "_ce_before_lock"}, 64'(early), 64'd0);
        chk({nm, "_ce0_first"}, 64'(p1), 64'd21);
        chk({nm, "_ce0_second"}, 64'(p2), 64'd26);
        chk({nm, "_all_first"}, 64'(ce21), 64'b111);
    endtask

    task automatic count_ce(input int ch, input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (ce_out[ch]) n++;
        end
    endtask

    initial begin
        int   n, errs, rlow;
        logic ce_at;

        repeat (3) @(negedge clk);
        chk("rst_ce", 64'(ce_out), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_err", 64'(cfg_err), 64'd0);
        chk_en = 1'b1;
        startup_check("boot");

        // ch1 -> 3/8, applied on ch1's next pulse.
        drive(1, 1, 3, 8);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("ch1_ready_low", 64'(cfg_ready), 64'd0);
        wait_ready("ch1", ce_at);
        chk("ch1_apply_on_pulse", 64'(ce_at), 64'd1);
        count_ce(1, 800, n);
        chk("ch1_3of8_800", 64'(n), 64'd300);

        // Three illegal requests.
        errs = 0; rlow = 0;
        for (int c = 0; c < 10; c++) begin
            if (cfg_err) errs++;
            if (!cfg_ready) rlow++;
            case (c)
                0: drive(1, 0, 9, 8);
                3: drive(1, 0, 0, 0);
                6: drive(1, 3, 1, 2);
                default: drive(0, 0, 0, 0);
            endcase
            @(negedge clk);
        end
        chk("illegal_err_count", 64'(errs), 64'd3);
        chk("illegal_ready_low", 64'(rlow), 64'd0);
        count_ce(1, 80, n);
        chk("ch1_rate_kept", 64'(n), 64'd30);
        count_ce(0, 80, n);
        chk("ch0_rate_kept", 64'(n), 64'd16);

        // ch0 off, then 2/2 applied immediately.
        drive(1, 0, 0, 5);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_ready("ch0", ce_at);
        chk("ch0_off_last_pulse", 64'(ce_at), 64'd1);
        count_ce(0, 20, n);
        chk("ch0_silent", 64'(n), 64'd0);
        drive(1, 0, 2, 2);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("ch0_imm_ready_low", 64'(cfg_ready), 64'd0);
        @(negedge clk);
        chk("ch0_imm_ready_back", 64'(cfg_ready), 64'd1);
        chk("ch0_imm_no_pulse", 64'(ce_out[0]), 64'd0);
        count_ce(0, 20, n);
        chk("ch0_full_rate", 64'(n), 64'd20);

        // Second request while pending is ignored.
        errs = 0;
        drive(1, 1, 1, 2);
        @(negedge clk);
        chk("dup_ready_low", 64'(cfg_ready), 64'd0);
        drive(1, 2, 2, 2);
        @(negedge clk);
        drive(0, 0, 0, 0);
        if (cfg_err) errs++;
        for (int c = 0; c < 40 && !cfg_ready; c++) begin
            @(negedge clk);
            if (cfg_err) errs++;
        end
        chk("dup_no_err", 64'(errs), 64'd0);
        chk("dup_ready_back", 64'(cfg_ready), 64'd1);
        count_ce(1, 40, n);
        chk("ch1_half_rate", 64'(n), 64'd20);
        count_ce(2, 40, n);
        chk("ch2_untouched", 64'(n), 64'd8);

        // Async reset while a request is pending.
        drive(1, 2, 1, 7);
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("mid_ready_low", 64'(cfg_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ce", 64'(ce_out), 64'd0);
        chk("async_locked", 64'(locked), 64'd0);
        chk("async_ready", 64'(cfg_ready), 64'd1);
        chk("async_err", 64'(cfg_err), 64'd0);
        repeat (2) @(negedge clk);
        startup_check("rerun");

`ifdef CLKEN_TOGGLE_EN
        n = 0;
        for (int c = 0; c < 20; c++) begin
            logic prev;
            prev = clk_toggle[0];
            @(negedge clk);
            if (clk_toggle[0] != prev) n++;
        end
        chk("toggle_flips_20", 64'(n), 64'd4);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
